// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction,
// decodes ALU control and immediate select, stalls on mem_ready and traps bad opcodes.
module multicycle_ctrl_fsm #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_UPPER    = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;

    assign w_ready = !MEM_WAIT || mem_ready;

    // Unsupported funct3 values (shifts, xor, sltu) still compute add but trap afterwards.
    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (funct3)
            3'b000:  w_funct_alu = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_R:             w_next = S_EXECR;
                    OP_I:             w_next = S_EXECI;
                    OP_BR:            w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OP_JAL:           w_next = S_JAL;
                    OP_LUI, OP_AUIPC: w_next = S_UPPER;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    w_next = w_funct_ok ? S_ALUWB : S_TRAP;
            S_JAL,
            S_UPPER:    w_next = S_ALUWB;
            S_ALUWB,
            S_BRANCH:   w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_pc_write = w_ready;
                w_ir_write = w_ready;
                result_src = 2'b10;
                alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_funct_alu;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_funct_alu;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                w_pc_write  = zero ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
            end
            S_UPPER: begin
                alu_src_a = op[5] ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst_n so an asynchronous reset cancels any write at once.
    assign pc_write  = rst_n & w_pc_write;
    assign ir_write  = rst_n & w_ir_write;
    assign mem_write = rst_n & w_mem_write;
    assign reg_write = rst_n & w_reg_write;

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_SW:            imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    assign illegal = (r_state == S_TRAP);
    assign state   = r_state;

endmodule
